regfile_sb: RTL and testbench

- Parametrised general-purpose register file for the pipelined MIPS-C core, successor to the single-configuration 2-read/1-write file.
- Adds configurable data width, depth and read-port count, plus asynchronous clear.
- Adds a per-register scoreboard: busy bits are set when an instruction issues with a destination and cleared on writeback. Decode uses them for hazard stalls.
- Sits between decode (reads, issue) and writeback (write port).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/regfile_sb.sv | 78 +++++++
 tb/tb_regfile_sb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file with scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned RA_MAX_W   = 128;

  // Extract read port k from a packed index bus (caller zero-extends to RA_MAX_W).
  function automatic logic [15:0] port_addr(input logic [RA_MAX_W-1:0] bus,
                                            input int unsigned k,
                                            input int unsigned aw);
    logic [15:0] mask;
    mask = (16'd1 << aw) - 16'd1;
    return 16'(bus >> (k * aw)) & mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits, issue acknowledge, flush and busy-count for regfile_sb.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  CLK_I,
  input  logic                  Reset_N_I,
  input  logic                  WE_I,
  input  logic [ADDR_W-1:0]     WAddr_I,
  input  logic                  Issue_I,
  input  logic [ADDR_W-1:0]     IssueAddr_I,
  input  logic                  Flush_I,
  output logic                  IssueAck_O,
  output logic [2**ADDR_W-1:0]  Busy_O,
  output logic [ADDR_W:0]       BusyCnt_O
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             set_en, inc, dec;

  always_comb begin
    IssueAck_O = Issue_I && !Flush_I &&
                 (!busy_q[IssueAddr_I] || (WE_I && (WAddr_I == IssueAddr_I)));
    set_en = IssueAck_O && !((ZERO_REG != 0) && (IssueAddr_I == ADDR_W'(REG_ZERO)));

    busy_d = busy_q;
    if (WE_I)   busy_d[WAddr_I] = 1'b0;
    if (set_en) busy_d[IssueAddr_I] = 1'b1;
    if (Flush_I) busy_d = '0;

    // Writeback and re-issue of the same busy index cancel: the register stays busy.
    inc = set_en && !busy_q[IssueAddr_I];
    dec = WE_I && busy_q[WAddr_I] && !(set_en && (IssueAddr_I == WAddr_I));
    cnt_d = cnt_q;
    if (Flush_I)        cnt_d = '0;
    else if (inc && !dec) cnt_d = cnt_q + (ADDR_W+1)'(1);
    else if (dec && !inc) cnt_d = cnt_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge CLK_I or negedge Reset_N_I) begin
    if (!Reset_N_I) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Busy_O    = busy_q;
  assign BusyCnt_O = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read register file with issue/writeback scoreboard.
// Optional write-to-read forwarding: define REGFILE_SB_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    CLK_I,
  input  logic                    Reset_N_I,
  input  logic [NREAD*ADDR_W-1:0] RAddr_I,
  output logic [NREAD*DATA_W-1:0] RData_O,
  output logic [NREAD-1:0]        RBusy_O,
  input  logic                    WE_I,
  input  logic [ADDR_W-1:0]       WAddr_I,
  input  logic [DATA_W-1:0]       WData_I,
  input  logic                    Issue_I,
  input  logic [ADDR_W-1:0]       IssueAddr_I,
  output logic                    IssueAck_O,
  input  logic                    Flush_I,
  output logic [ADDR_W:0]         BusyCnt_O
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]   rf [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic [RA_MAX_W-1:0] raddr_bus;
  logic                wr_en;

  regfile_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .CLK_I       (CLK_I),
    .Reset_N_I   (Reset_N_I),
    .WE_I        (WE_I),
    .WAddr_I     (WAddr_I),
    .Issue_I     (Issue_I),
    .IssueAddr_I (IssueAddr_I),
    .Flush_I     (Flush_I),
    .IssueAck_O  (IssueAck_O),
    .Busy_O      (busy),
    .BusyCnt_O   (BusyCnt_O)
  );

  assign wr_en     = WE_I && !((ZERO_REG != 0) && (WAddr_I == ADDR_W'(REG_ZERO)));
  assign raddr_bus = RA_MAX_W'(RAddr_I);

  always_ff @(posedge CLK_I or negedge Reset_N_I) begin
    if (!Reset_N_I) begin
      for (int unsigned i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[WAddr_I] <= WData_I;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    RData_O = '0;
    RBusy_O = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      ra = ADDR_W'(port_addr(raddr_bus, k, ADDR_W));
      RData_O[k*DATA_W +: DATA_W] = rf[ra];
      RBusy_O[k] = busy[ra];
      if ((ZERO_REG != 0) && (ra == ADDR_W'(REG_ZERO))) begin
        RData_O[k*DATA_W +: DATA_W] = '0;
        RBusy_O[k] = 1'b0;
      end
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_en && (WAddr_I == ra)) begin
        RData_O[k*DATA_W +: DATA_W] = WData_I;
        RBusy_O[k] = IssueAck_O && (IssueAddr_I == ra);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (NREAD=3, 32x32, ZERO_REG=1).
module tb_regfile_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]  rbusy;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic           issue;
  logic [AW-1:0]  iaddr;
  logic           iack;
  logic           flush;
  logic [AW:0]    bcnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut (
    .CLK_I       (clk),
    .Reset_N_I   (rst_n),
    .RAddr_I     (raddr),
    .RData_O     (rdata),
    .RBusy_O     (rbusy),
    .WE_I        (we),
    .WAddr_I     (waddr),
    .WData_I     (wdata),
    .Issue_I     (issue),
    .IssueAddr_I (iaddr),
    .IssueAck_O  (iack),
    .Flush_I     (flush),
    .BusyCnt_O   (bcnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rd(input int unsigned k);
    return rdata[k*DW +: DW];
  endfunction

  task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    raddr = {a2, a1, a0};
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    issue = 1'b0; iaddr = '0; flush = 1'b0;
    set_raddr(5'd5, 5'd7, 5'd0);
    #3;
    check_eq("reset_cnt", 64'(bcnt), 64'd0);
    check_eq("reset_rdata", 64'(rd(0)), 64'd0);
    #4 rst_n = 1'b1;
    tick();

    // Reset mid-run
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    issue = 1'b1; iaddr = 5'd7;
    #1 check_eq("r7_ack", 64'(iack), 64'd1);
    tick();
    issue = 1'b0;
    #1;
    check_eq("r5_before_rst", 64'(rd(0)), 64'hDEADBEEF);
    check_eq("r7_busy", 64'(rbusy[1]), 64'd1);
    check_eq("cnt_before_rst", 64'(bcnt), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("r5_async_rst", 64'(rd(0)), 64'd0);
    check_eq("r7_busy_rst", 64'(rbusy[1]), 64'd0);
    check_eq("cnt_async_rst", 64'(bcnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic write/read, three ports, zero register
    for (int unsigned i = 1; i <= 3; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = DW'(i * 32'h11);
      tick();
    end
    waddr = 5'd0; wdata = 32'hFFFFFFFF;
    tick();
    we = 1'b0;
    set_raddr(5'd1, 5'd2, 5'd3);
    #1;
    check_eq("rd_p0_r1", 64'(rd(0)), 64'h11);
    check_eq("rd_p1_r2", 64'(rd(1)), 64'h22);
    check_eq("rd_p2_r3", 64'(rd(2)), 64'h33);
    set_raddr(5'd0, 5'd0, 5'd0);
    #1 check_eq("rd_r0_zero", 64'(rd(0)), 64'd0);

    // Scoreboard issue / stall / writeback
    set_raddr(5'd4, 5'd0, 5'd0);
    issue = 1'b1; iaddr = 5'd4;
    #1 check_eq("r4_ack1", 64'(iack), 64'd1);
    tick();
    #1;
    check_eq("r4_waw_ack0", 64'(iack), 64'd0);
    check_eq("r4_busy", 64'(rbusy[0]), 64'd1);
    check_eq("cnt_r4", 64'(bcnt), 64'd1);
    tick();
    issue = 1'b0;
    #1 check_eq("cnt_after_nack", 64'(bcnt), 64'd1);
    we = 1'b1; waddr = 5'd4; wdata = 32'h44;
    tick();
    we = 1'b0;
    #1;
    check_eq("r4_busy_clr", 64'(rbusy[0]), 64'd0);
    check_eq("cnt_wb", 64'(bcnt), 64'd0);
    check_eq("r4_data", 64'(rd(0)), 64'h44);

    // Same-cycle writeback plus re-issue
    issue = 1'b1; iaddr = 5'd4;
    tick();
    issue = 1'b0;
    #1 check_eq("cnt_reissue", 64'(bcnt), 64'd1);
    we = 1'b1; waddr = 5'd4; wdata = 32'h4444;
    issue = 1'b1; iaddr = 5'd4;
    #1 check_eq("same_cyc_ack", 64'(iack), 64'd1);
    tick();
    we = 1'b0; issue = 1'b0;
    #1;
    check_eq("same_cyc_busy", 64'(rbusy[0]), 64'd1);
    check_eq("same_cyc_data", 64'(rd(0)), 64'h4444);
    check_eq("same_cyc_cnt", 64'(bcnt), 64'd1);
    we = 1'b1; waddr = 5'd4; wdata = 32'h4444;
    tick();
    we = 1'b0;
    #1 check_eq("cnt_clear_r4", 64'(bcnt), 64'd0);

    // Flush
    for (int unsigned i = 8; i <= 10; i++) begin
      issue = 1'b1; iaddr = AW'(i);
      tick();
    end
    issue = 1'b0;
    #1 check_eq("cnt_three", 64'(bcnt), 64'd3);
    flush = 1'b1; issue = 1'b1; iaddr = 5'd11;
    #1 check_eq("flush_nack", 64'(iack), 64'd0);
    tick();
    flush = 1'b0; issue = 1'b0;
    set_raddr(5'd8, 5'd9, 5'd11);
    #1;
    check_eq("flush_cnt", 64'(bcnt), 64'd0);
    check_eq("flush_busy", 64'(rbusy), 64'd0);

    // Write-to-read forwarding
    set_raddr(5'd6, 5'd0, 5'd0);
    we = 1'b1; waddr = 5'd6; wdata = 32'h66;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    check_eq("byp_data", 64'(rd(0)), 64'h66);
`else
    check_eq("nobyp_data", 64'(rd(0)), 64'd0);
`endif
    check_eq("byp_busy", 64'(rbusy[0]), 64'd0);
    tick();
    we = 1'b0;
    #1 check_eq("r6_after", 64'(rd(0)), 64'h66);
    we = 1'b1; waddr = 5'd6; wdata = 32'h67;
    issue = 1'b1; iaddr = 5'd6;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    check_eq("byp_issue_busy", 64'(rbusy[0]), 64'd1);
    check_eq("byp_issue_data", 64'(rd(0)), 64'h67);
`else
    check_eq("nobyp_issue_busy", 64'(rbusy[0]), 64'd0);
    check_eq("nobyp_issue_data", 64'(rd(0)), 64'h66);
`endif
    tick();
    we = 1'b0; issue = 1'b0;
    #1;
    check_eq("r6_busy_next", 64'(rbusy[0]), 64'd1);
    check_eq("r6_data_next", 64'(rd(0)), 64'h67);
    check_eq("cnt_r6", 64'(bcnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
